sixty_countdown: RTL and testbench

//  MM:SS countdown timer built from two mod-60 down-count fields (minutes, seconds); the counting-down

---
 rtl/sixty_countdown.sv | 152 +++++++++++++++
 tb/tb_sixty_countdown.sv | 340 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sixty_countdown.sv
// MM:SS countdown timer: two mod-(FIELD_MAX+1) down-count fields, button preset, start/stop, 1-cycle Expire.
// Define SIXTY_COUNTDOWN_AUTORELOAD_EN to reload the preset at 00:00 and keep running instead of entering DONE.
module sixty_countdown #(
  parameter int TICK_DIV  = 50_000_000,
  parameter int FIELD_MAX = 59
) (
  input  logic       Clk_50MHz,
  input  logic       Reset_N,
  input  logic       Start,
  input  logic       Stop,
  input  logic       Add,
  input  logic       Subtract,
  input  logic       Sel,
  output logic [5:0] sec_count,
  output logic [5:0] min_count,
  output logic       Running,
  output logic       Done_led,
  output logic       Expire
);

  localparam int            PW         = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
  localparam logic [5:0]    FMAX       = 6'(FIELD_MAX);

  typedef enum logic [1:0] {IDLE, RUN, PAUSE, DONE} state_t;

  state_t        state, state_nx;
  logic [3:0]    btn_s1, btn_s2, btn_prev;   // {Subtract, Add, Stop, Start}
  logic          sel_s1, sel_s2;
  logic          start_p, stop_p, add_p, sub_p;
  logic [5:0]    sec_q, min_q, sec_nx, min_nx;
  logic [5:0]    psec_q, pmin_q, psec_nx, pmin_nx;
  logic [5:0]    fld, fld_adj;
  logic [PW-1:0] presc_q, presc_nx;
  logic          expire_q, expire_nx;
  logic          nonzero;

  always_ff @(posedge Clk_50MHz or negedge Reset_N) begin
    if (!Reset_N) begin
      btn_s1   <= '0;
      btn_s2   <= '0;
      btn_prev <= '0;
      sel_s1   <= 1'b0;
      sel_s2   <= 1'b0;
      state    <= IDLE;
      sec_q    <= '0;
      min_q    <= '0;
      psec_q   <= '0;
      pmin_q   <= '0;
      presc_q  <= '0;
      expire_q <= 1'b0;
    end else begin
      btn_s1   <= {Subtract, Add, Stop, Start};
      btn_s2   <= btn_s1;
      btn_prev <= btn_s2;
      sel_s1   <= Sel;
      sel_s2   <= sel_s1;
      state    <= state_nx;
      sec_q    <= sec_nx;
      min_q    <= min_nx;
      psec_q   <= psec_nx;
      pmin_q   <= pmin_nx;
      presc_q  <= presc_nx;
      expire_q <= expire_nx;
    end
  end

  // A held level produces exactly one pulse, on its synchronised rising edge.
  assign {sub_p, add_p, stop_p, start_p} = btn_s2 & ~btn_prev;
  assign nonzero = (sec_q != 6'd0) || (min_q != 6'd0);

  always_comb begin
    fld     = sel_s2 ? min_q : sec_q;
    fld_adj = fld;
    if (add_p && !sub_p)
      fld_adj = (fld == FMAX) ? 6'd0 : fld + 6'd1;
    else if (sub_p && !add_p)
      fld_adj = (fld == 6'd0) ? FMAX : fld - 6'd1;
  end

  always_comb begin
    state_nx  = state;
    sec_nx    = sec_q;
    min_nx    = min_q;
    psec_nx   = psec_q;
    pmin_nx   = pmin_q;
    presc_nx  = presc_q;
    expire_nx = 1'b0;
    case (state)
      IDLE: begin
        if (start_p && !stop_p && nonzero) begin
          state_nx = RUN;
          presc_nx = '0;
        end else if (add_p ^ sub_p) begin
          if (sel_s2) min_nx = fld_adj;
          else        sec_nx = fld_adj;
          psec_nx = sel_s2 ? sec_q : fld_adj;
          pmin_nx = sel_s2 ? fld_adj : min_q;
        end
      end
      RUN: begin
        if (stop_p) begin
          state_nx = PAUSE;
        end else if (presc_q == PRESC_LAST) begin
          presc_nx = '0;
          if (sec_q != 6'd0) begin
            sec_nx = sec_q - 6'd1;
          end else if (min_q != 6'd0) begin
            sec_nx = FMAX;
            min_nx = min_q - 6'd1;
          end
          // This tick lands on 00:00.
          if (sec_q == 6'd1 && min_q == 6'd0) begin
            expire_nx = 1'b1;
`ifdef SIXTY_COUNTDOWN_AUTORELOAD_EN
            sec_nx = psec_q;
            min_nx = pmin_q;
`else
            state_nx = DONE;
`endif
          end
        end else begin
          presc_nx = presc_q + PW'(1);
        end
      end
      PAUSE: begin
        if (stop_p) begin
          state_nx = IDLE;
          sec_nx   = psec_q;
          min_nx   = pmin_q;
        end else if (start_p) begin
          state_nx = RUN;
        end
      end
      DONE: begin
        if (start_p || stop_p) begin
          state_nx = IDLE;
          sec_nx   = psec_q;
          min_nx   = pmin_q;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  assign sec_count = sec_q;
  assign min_count = min_q;
  assign Running   = (state == RUN);
  assign Done_led  = (state == DONE);
  assign Expire    = expire_q;

endmodule

// File: tb/tb_sixty_countdown.sv
// Bench for sixty_countdown: directed scenarios plus randomized buttons against a seconds-total reference model.
`timescale 1ns/1ps
module tb_sixty_countdown;

  localparam int TD = 4;
  localparam int B_START = 0, B_STOP = 1, B_ADD = 2, B_SUB = 3;
  localparam int M_IDLE = 0, M_RUN = 1, M_PAUSE = 2, M_DONE = 3;

  logic       clk = 1'b0, rst_n = 1'b0;
  logic       start = 1'b0, stop = 1'b0, add = 1'b0, sub = 1'b0, sel = 1'b0;
  logic [5:0] sec_count, min_count;
  logic       running, done_led, expire;
  int         checks = 0, errors = 0;

  sixty_countdown #(.TICK_DIV(TD), .FIELD_MAX(59)) dut (
    .Clk_50MHz(clk), .Reset_N(rst_n), .Start(start), .Stop(stop), .Add(add),
    .Subtract(sub), .Sel(sel), .sec_count(sec_count), .min_count(min_count),
    .Running(running), .Done_led(done_led), .Expire(expire)
  );

  always #5 clk = ~clk;

  // Reference model: time kept as a total of seconds, buttons seen two samples late.
  int         m_mode = M_IDLE, m_sec = 0, m_min = 0, p_sec = 0, p_min = 0, m_cyc = 0, m_tot = 0, m_d = 0;
  bit         m_exp = 1'b0;
  logic [4:0] h0 = '0, h1 = '0, h2 = '0, m_ev = '0;

  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      m_mode = M_IDLE; m_sec = 0; m_min = 0; p_sec = 0; p_min = 0; m_cyc = 0; m_exp = 1'b0;
      h0 = '0; h1 = '0; h2 = '0;
    end else begin
      m_ev = h1 & ~h2;
      m_exp = 1'b0;
      case (m_mode)
        M_IDLE: begin
          if (m_ev[B_START] && !m_ev[B_STOP] && (m_sec + m_min) > 0) begin
            m_mode = M_RUN; m_cyc = 0;
          end else if (m_ev[B_ADD] != m_ev[B_SUB]) begin
            m_d = m_ev[B_ADD] ? 1 : 59;
            if (h1[4]) m_min = (m_min + m_d) % 60;
            else       m_sec = (m_sec + m_d) % 60;
            p_sec = m_sec; p_min = m_min;
          end
        end
        M_RUN: begin
          if (m_ev[B_STOP]) m_mode = M_PAUSE;
          else begin
            m_cyc++;
            if (m_cyc == TD) begin
              m_cyc = 0;
              m_tot = m_min * 60 + m_sec - 1;
              m_min = m_tot / 60; m_sec = m_tot % 60;
              if (m_tot == 0) begin
                m_exp = 1'b1;
`ifdef SIXTY_COUNTDOWN_AUTORELOAD_EN
                m_sec = p_sec; m_min = p_min;
`else
                m_mode = M_DONE;
`endif
              end
            end
          end
        end
        M_PAUSE: begin
          if (m_ev[B_STOP]) begin m_mode = M_IDLE; m_sec = p_sec; m_min = p_min; end
          else if (m_ev[B_START]) m_mode = M_RUN;
        end
        default: begin
          if (m_ev[B_START] || m_ev[B_STOP]) begin m_mode = M_IDLE; m_sec = p_sec; m_min = p_min; end
        end
      endcase
      h2 = h1; h1 = h0; h0 = {sel, sub, add, stop, start};
    end
  end

  logic [14:0] dut_v, exp_v;
  assign dut_v = {min_count, sec_count, running, done_led, expire};
  assign exp_v = {6'(m_min), 6'(m_sec), m_mode == M_RUN, m_mode == M_DONE, m_exp};

  initial begin
    #1ms;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  task automatic press(input int which, input int hold);
    case (which)
      B_START: start = 1'b1;
      B_STOP:  stop  = 1'b1;
      B_ADD:   add   = 1'b1;
      default: sub   = 1'b1;
    endcase
    repeat (hold) @(negedge clk);
    start = 1'b0; stop = 1'b0; add = 1'b0; sub = 1'b0;
  endtask

  task automatic tap(input int which);
    press(which, 3);
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; sel = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (dut_v !== 15'd0) begin errors++; $display("FAIL reset_state got %h expected 0", dut_v); end
    rst_n = 1'b1;
    @(negedge clk);
    repeat (30) tap(B_ADD);
    tap(B_START);
    checks++;
    if (running !== 1'b1 || sec_count !== 6'd30 || min_count !== 6'd0) begin
      errors++; $display("FAIL run_at_0030 got %0d:%0d run=%b expected 0:30 run=1", min_count, sec_count, running);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (dut_v !== 15'd0) begin errors++; $display("FAIL async_reset got %h expected 0", dut_v); end
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (dut_v !== exp_v) begin errors++; $display("FAIL reset_model got %h expected %h", dut_v, exp_v); end
  endtask

  task automatic test_wrap();
    sel = 1'b0;
    tap(B_SUB);
    checks++;
    if (sec_count !== 6'd59 || min_count !== 6'd0) begin
      errors++; $display("FAIL sec_underflow got %0d:%0d expected 0:59", min_count, sec_count);
    end
    tap(B_ADD);
    checks++;
    if (sec_count !== 6'd0 || min_count !== 6'd0) begin
      errors++; $display("FAIL sec_overflow got %0d:%0d expected 0:0", min_count, sec_count);
    end
    sel = 1'b1;
    for (int i = 1; i <= 60; i++) begin
      tap(B_ADD);
      if (i >= 59) begin
        checks++;
        if (min_count !== 6'(i % 60) || sec_count !== 6'd0) begin
          errors++; $display("FAIL min_wrap_%0d got %0d:%0d expected %0d:0", i, min_count, sec_count, i % 60);
        end
      end
    end
  endtask

  task automatic test_countdown();
    int c;
    sel = 1'b1; tap(B_ADD);
    sel = 1'b0; tap(B_ADD);
    checks++;
    if (min_count !== 6'd1 || sec_count !== 6'd1 || running !== 1'b0) begin
      errors++; $display("FAIL preset_0101 got %0d:%0d run=%b expected 1:1 run=0", min_count, sec_count, running);
    end
    press(B_START, 3);
    checks++;
    if (running !== 1'b1 || sec_count !== 6'd1) begin
      errors++; $display("FAIL run_entry got run=%b sec=%0d expected run=1 sec=1", running, sec_count);
    end
    repeat (3) @(negedge clk);
    checks++;
    if (sec_count !== 6'd1 || min_count !== 6'd1) begin
      errors++; $display("FAIL early_tick got %0d:%0d expected 1:1", min_count, sec_count);
    end
    @(negedge clk);
    checks++;
    if (sec_count !== 6'd0 || min_count !== 6'd1) begin
      errors++; $display("FAIL first_tick got %0d:%0d expected 1:0", min_count, sec_count);
    end
    repeat (4) @(negedge clk);
    checks++;
    if (sec_count !== 6'd59 || min_count !== 6'd0) begin
      errors++; $display("FAIL borrow_tick got %0d:%0d expected 0:59", min_count, sec_count);
    end
    c = 8;
    while (expire !== 1'b1 && c < 400) begin @(negedge clk); c++; end
    checks++;
    if (c != 244) begin errors++; $display("FAIL expire_time got %0d expected 244", c); end
    @(negedge clk);
    checks++;
`ifdef SIXTY_COUNTDOWN_AUTORELOAD_EN
    if (expire !== 1'b0 || running !== 1'b1 || done_led !== 1'b0 || min_count !== 6'd1 || sec_count !== 6'd1) begin
      errors++; $display("FAIL after_expire got %h expected reload 1:1 running", dut_v);
    end
`else
    if (expire !== 1'b0 || running !== 1'b0 || done_led !== 1'b1 || min_count !== 6'd0 || sec_count !== 6'd0) begin
      errors++; $display("FAIL after_expire got %h expected done 0:0", dut_v);
    end
`endif
    checks++;
    if (dut_v !== exp_v) begin errors++; $display("FAIL countdown_model got %h expected %h", dut_v, exp_v); end
  endtask

  task automatic test_pause();
    int c;
    bit bad;
    logic [5:0] hs, hm;
    tap(B_STOP); tap(B_STOP);
    checks++;
    if (running !== 1'b0 || done_led !== 1'b0 || min_count !== 6'd1 || sec_count !== 6'd1) begin
      errors++; $display("FAIL back_to_idle got %h expected idle 1:1", dut_v);
    end
    tap(B_START);
    c = 0;
    while (!(min_count == 6'd0 && sec_count == 6'd30) && c < 400) begin @(negedge clk); c++; end
    checks++;
    if (c >= 400) begin errors++; $display("FAIL reach_0030 got timeout expected 0:30"); end
    press(B_STOP, 3);
    checks++;
    if (dut_v !== exp_v || running !== 1'b0) begin
      errors++; $display("FAIL pause_entry got %h expected %h", dut_v, exp_v);
    end
    hs = sec_count; hm = min_count; bad = 1'b0;
    repeat (100) begin
      @(negedge clk);
      if (sec_count !== hs || min_count !== hm || running !== 1'b0) bad = 1'b1;
    end
    checks++;
    if (bad) begin errors++; $display("FAIL pause_hold got changed=1 expected changed=0"); end
    press(B_START, 3);
    c = 0;
    while (sec_count === hs && c < 20) begin @(negedge clk); c++; end
    checks++;
    if (c < 1 || c > 4) begin errors++; $display("FAIL resume_latency got %0d expected 1..4", c); end
    checks++;
    if (dut_v !== exp_v) begin errors++; $display("FAIL resume_model got %h expected %h", dut_v, exp_v); end
    tap(B_STOP); tap(B_STOP);
    checks++;
    if (running !== 1'b0 || min_count !== 6'd1 || sec_count !== 6'd1) begin
      errors++; $display("FAIL stop_stop_reload got %0d:%0d run=%b expected 1:1 run=0", min_count, sec_count, running);
    end
  endtask

  task automatic test_edge_cases();
    sel = 1'b0; tap(B_SUB);
    sel = 1'b1; tap(B_SUB);
    tap(B_START);
    repeat (2) @(negedge clk);
    checks++;
    if (running !== 1'b0 || min_count !== 6'd0 || sec_count !== 6'd0) begin
      errors++; $display("FAIL start_at_zero got %h expected idle 0:0", dut_v);
    end
    sel = 1'b0; tap(B_ADD);
    start = 1'b1; stop = 1'b1;
    repeat (3) @(negedge clk);
    start = 1'b0; stop = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (running !== 1'b0 || done_led !== 1'b0 || sec_count !== 6'd1) begin
      errors++; $display("FAIL start_stop_same got %h expected idle 0:1", dut_v);
    end
    add = 1'b1; sub = 1'b1;
    repeat (3) @(negedge clk);
    add = 1'b0; sub = 1'b0;
    @(negedge clk);
    checks++;
    if (sec_count !== 6'd1 || min_count !== 6'd0) begin
      errors++; $display("FAIL add_sub_same got %0d:%0d expected 0:1", min_count, sec_count);
    end
    press(B_ADD, 50);
    @(negedge clk);
    checks++;
    if (sec_count !== 6'd2) begin errors++; $display("FAIL held_add got %0d expected 2", sec_count); end
  endtask

  task automatic test_expire_mode();
    int c;
    bit bad;
    press(B_START, 3);
    bad = 1'b0;
`ifdef SIXTY_COUNTDOWN_AUTORELOAD_EN
    for (int k = 0; k < 3; k++) begin
      c = 0;
      while (c < 40) begin
        @(negedge clk); c++;
        if (running !== 1'b1 || done_led !== 1'b0) bad = 1'b1;
        if (expire === 1'b1) break;
      end
      checks++;
      if (c != 8) begin errors++; $display("FAIL reload_period_%0d got %0d expected 8", k, c); end
    end
    checks++;
    if (bad) begin errors++; $display("FAIL reload_status got bad=1 expected running only"); end
    tap(B_STOP); tap(B_STOP);
`else
    c = 0;
    while (expire !== 1'b1 && c < 40) begin @(negedge clk); c++; end
    checks++;
    if (c != 8) begin errors++; $display("FAIL expire_0002 got %0d expected 8", c); end
    repeat (50) begin
      @(negedge clk);
      if (done_led !== 1'b1 || running !== 1'b0 || expire !== 1'b0 || sec_count !== 6'd0) bad = 1'b1;
    end
    checks++;
    if (bad) begin errors++; $display("FAIL done_hold got bad=1 expected steady done 0:0"); end
    tap(B_START);
`endif
    checks++;
    if (running !== 1'b0 || done_led !== 1'b0 || sec_count !== 6'd2 || min_count !== 6'd0) begin
      errors++; $display("FAIL expire_exit got %h expected idle 0:2", dut_v);
    end
  endtask

  task automatic test_random();
    int fails;
    fails = 0;
    for (int i = 0; i < 1500; i++) begin
      @(negedge clk);
      checks++;
      if (dut_v !== exp_v) begin
        errors++;
        if (fails < 10) $display("FAIL random_cycle_%0d got %h expected %h", i, dut_v, exp_v);
        fails++;
      end
      if ($urandom_range(9) == 0)  start = ~start;
      if ($urandom_range(29) == 0) stop  = ~stop;
      if ($urandom_range(4) == 0)  add   = ~add;
      if ($urandom_range(6) == 0)  sub   = ~sub;
      if ($urandom_range(7) == 0)  sel   = ~sel;
    end
    start = 1'b0; stop = 1'b0; add = 1'b0; sub = 1'b0;
  endtask

  initial begin
    test_reset();
    test_wrap();
    test_countdown();
    test_pause();
    test_edge_cases();
    test_expire_mode();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
